wb_bram_arbiter: RTL and testbench
==================================

WB_BRAM_ARBITER -- requirements
Module: wb_bram_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles from grant to slave ack before abort (range 2..255).
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_mN_stb  in  1  request strobe from master N, N in {0 = hart data port, 1 = loader}.
REQ-006 i_mN_we  in  1  write enable from master N.
REQ-007 i_mN_sel  in  3  access size/select from master N, passed through unchanged.
REQ-008 i_mN_addr  in  XLEN  byte address from master N.
REQ-009 i_mN_data  in  XLEN  write data from master N.
REQ-010 o_mN_stall  out  1  master N request not accepted this cycle.
REQ-011 o_mN_ack  out  1  one-cycle completion pulse to master N.
REQ-012 o_mN_err  out  1  one-cycle timeout-abort pulse to master N.
REQ-013 o_mN_data  out  XLEN  read data to master N, valid while o_mN_ack=1.
REQ-014 o_s_stb, o_s_we  out  1 each  strobe and write enable to block RAM.
REQ-015 o_s_sel  out  3; o_s_addr, o_s_data  out  XLEN  latched request fields to block RAM.
REQ-016 i_s_data  in  XLEN; i_s_stall, i_s_ack  in  1 each  block RAM read data, stall, ack.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; exactly one outstanding slave transaction.
REQ-018 IDLE: winner = sole requesting master; if both stb=1, master indicated by round-robin pointer rr.
REQ-019 IDLE: o_mN_stall = 0 for winner and for any non-requesting master; = 1 for a requesting loser.
REQ-020 IDLE, winner present: latch we/sel/addr/data, record owner, set rr to the other master, go ISSUE.
REQ-021 ISSUE and WAIT: o_m0_stall = o_m1_stall = 1.
REQ-022 ISSUE: o_s_stb=1 with latched fields; if i_s_stall=0, go WAIT next cycle; else hold.
REQ-023 WAIT: o_s_stb=0; wait for i_s_ack.
REQ-024 i_s_ack=1 in ISSUE (with i_s_stall=0) or WAIT completes: next cycle o_owner_ack=1 and o_owner_data=registered i_s_data; state IDLE.
REQ-025 Hence minimum latency: accept edge -> ack pulse 3 cycles later with zero-wait slave (ISSUE, WAIT, ack).
REQ-026 A new request may be accepted in the same IDLE cycle that an ack/err pulse is driven.
REQ-027 8-bit counter cleared on accept, incremented each ISSUE/WAIT cycle; reaching TIMEOUT without ack: o_s_stb dropped, next cycle o_owner_err=1, o_owner_ack=0, state IDLE.
REQ-028 Ack and timeout in same cycle: ack wins, no err.
REQ-029 i_s_ack in IDLE is ignored; no master pulse.
REQ-030 Non-owner master never sees ack/err; o_mN_data = 0 when o_mN_ack = 0.
REQ-031 o_mN_ack and o_mN_err are never both 1; each exactly one cycle.

Reset
REQ-032 i_reset_n=0: immediately state IDLE, rr=0 (master 0 priority), counter 0, owner 0, latched fields 0.
REQ-033 During reset all outputs 0, including o_mN_stall.
REQ-034 Reset mid-transaction drops it silently: no ack or err pulse afterwards.

Structure
REQ-035 Package wb_arb_pkg holds state enum (IDLE/ISSUE/WAIT), SEL_W=3, default TIMEOUT.
REQ-036 One sub-module arb_rr2: combinational two-way round-robin pick (req[1:0], rr -> grant[1:0]).

Verification
REQ-037 Single read: m0 stb, addr 0x10, slave acks in WAIT with data 0xDEADBEEF -> o_m0_ack one cycle, o_m0_data=0xDEADBEEF, 3 cycles after accept.
REQ-038 Contention: m0 and m1 stb same cycle after reset -> m0 granted, m1 stalled; after m0 ack both again -> m1 granted.
REQ-039 Slave stall: i_s_stall=1 for 4 cycles in ISSUE -> o_s_stb held 5 cycles, fields stable, then WAIT, ack delivered.
REQ-040 Timeout: TIMEOUT=15, slave never acks -> o_m1_err pulse at cycle 16 after accept, no ack, next request accepted.
REQ-041 Reset in WAIT: i_reset_n low one cycle then slave ack -> no o_mN_ack, FSM IDLE, rr=0.
REQ-042 Write pass-through: m1 we=1 sel=3'b010 addr 0x24 data 0x1234 -> o_s_* match exactly while o_s_stb=1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone block-RAM arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } arb_state_e;

   localparam int unsigned SEL_W       = 3;
   localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the master
// named by rr.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       rr,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = rr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter in front of a single block RAM port, one outstanding
// transaction at a time, with a grant-to-ack timeout.
module wb_bram_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_m0_stb,
   input  logic             i_m0_we,
   input  logic [SEL_W-1:0] i_m0_sel,
   input  logic [XLEN-1:0]  i_m0_addr,
   input  logic [XLEN-1:0]  i_m0_data,
   output logic             o_m0_stall,
   output logic             o_m0_ack,
   output logic             o_m0_err,
   output logic [XLEN-1:0]  o_m0_data,
   input  logic             i_m1_stb,
   input  logic             i_m1_we,
   input  logic [SEL_W-1:0] i_m1_sel,
   input  logic [XLEN-1:0]  i_m1_addr,
   input  logic [XLEN-1:0]  i_m1_data,
   output logic             o_m1_stall,
   output logic             o_m1_ack,
   output logic             o_m1_err,
   output logic [XLEN-1:0]  o_m1_data,
   output logic             o_s_stb,
   output logic             o_s_we,
   output logic [SEL_W-1:0] o_s_sel,
   output logic [XLEN-1:0]  o_s_addr,
   output logic [XLEN-1:0]  o_s_data,
   input  logic [XLEN-1:0]  i_s_data,
   input  logic             i_s_stall,
   input  logic             i_s_ack
);

   // Last counter value at which an ack is still accepted; without one, abort.
   localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

   arb_state_e       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             rr_q, rr_d;
   logic             we_q, we_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [XLEN-1:0]  rdata_q, rdata_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [1:0]       grant;
   logic             stall0, stall1, s_stb;

   arb_rr2 u_arb_rr2 (
      .req   ({i_m1_stb, i_m0_stb}),
      .rr    (rr_q),
      .grant (grant)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      stall0  = 1'b1;
      stall1  = 1'b1;
      s_stb   = 1'b0;
      case (state_q)
         StIdle: begin
            stall0 = i_m0_stb & ~grant[0];
            stall1 = i_m1_stb & ~grant[1];
            if (grant != 2'b00) begin
               owner_d = grant[1];
               rr_d    = ~grant[1];
               cnt_d   = 8'd0;
               we_d    = grant[1] ? i_m1_we   : i_m0_we;
               sel_d   = grant[1] ? i_m1_sel  : i_m0_sel;
               addr_d  = grant[1] ? i_m1_addr : i_m0_addr;
               wdata_d = grant[1] ? i_m1_data : i_m0_data;
               state_d = StIssue;
            end
         end
         StIssue: begin
            s_stb = 1'b1;
            cnt_d = cnt_q + 8'd1;
            if (!i_s_stall && i_s_ack) begin
               ack_d   = 1'b1;
               rdata_d = i_s_data;
               state_d = StIdle;
            end else if (cnt_q == TmoLast) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else if (!i_s_stall) begin
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 8'd1;
            if (i_s_ack) begin
               ack_d   = 1'b1;
               rdata_d = i_s_data;
               state_d = StIdle;
            end else if (cnt_q == TmoLast) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         owner_q <= 1'b0;
         rr_q    <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Stall is combinational on the strobes, so hold it low explicitly while in reset.
   assign o_m0_stall = stall0 & i_reset_n;
   assign o_m1_stall = stall1 & i_reset_n;
   assign o_m0_ack   = ack_q & ~owner_q;
   assign o_m1_ack   = ack_q & owner_q;
   assign o_m0_err   = err_q & ~owner_q;
   assign o_m1_err   = err_q & owner_q;
   assign o_m0_data  = o_m0_ack ? rdata_q : '0;
   assign o_m1_data  = o_m1_ack ? rdata_q : '0;
   assign o_s_stb    = s_stb;
   assign o_s_we     = we_q;
   assign o_s_sel    = sel_q;
   assign o_s_addr   = addr_q;
   assign o_s_data   = wdata_q;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed self-checking bench for wb_bram_arbiter: reset, arbitration, stall,
// timeout, reset abort and write pass-through.
module tb_wb_bram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_stb, m0_we, m1_stb, m1_we;
   logic [2:0]  m0_sel, m1_sel, s_sel;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_stb, s_we, s_stall, s_ack;
   logic [31:0] s_addr, s_wdata, s_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_bram_arbiter #(.XLEN(32), .TIMEOUT(15)) dut (
      .i_clk      (clk),
      .i_reset_n  (reset_n),
      .i_m0_stb   (m0_stb),
      .i_m0_we    (m0_we),
      .i_m0_sel   (m0_sel),
      .i_m0_addr  (m0_addr),
      .i_m0_data  (m0_wdata),
      .o_m0_stall (m0_stall),
      .o_m0_ack   (m0_ack),
      .o_m0_err   (m0_err),
      .o_m0_data  (m0_rdata),
      .i_m1_stb   (m1_stb),
      .i_m1_we    (m1_we),
      .i_m1_sel   (m1_sel),
      .i_m1_addr  (m1_addr),
      .i_m1_data  (m1_wdata),
      .o_m1_stall (m1_stall),
      .o_m1_ack   (m1_ack),
      .o_m1_err   (m1_err),
      .o_m1_data  (m1_rdata),
      .o_s_stb    (s_stb),
      .o_s_we     (s_we),
      .o_s_sel    (s_sel),
      .o_s_addr   (s_addr),
      .o_s_data   (s_wdata),
      .i_s_data   (s_rdata),
      .i_s_stall  (s_stall),
      .i_s_ack    (s_ack)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset_n = 1'b0;
      m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 3'b000; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_stb = 1'b1; m1_we = 1'b0; m1_sel = 3'b000; m1_addr = 32'h0; m1_wdata = 32'h0;
      s_stall = 1'b0; s_ack = 1'b0; s_rdata = 32'h0;

      // Reset: every output low, even with both strobes up.
      tick();
      check_eq("rst_m0_stall", {31'd0, m0_stall}, 32'd0);
      check_eq("rst_m1_stall", {31'd0, m1_stall}, 32'd0);
      check_eq("rst_s_stb", {31'd0, s_stb}, 32'd0);
      check_eq("rst_acks", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
      check_eq("rst_s_addr", s_addr, 32'd0);
      m0_stb = 1'b0; m1_stb = 1'b0;
      reset_n = 1'b1;
      tick();

      // Contention right after reset: m0 wins, then m1 on the next round.
      m0_stb = 1'b1; m0_addr = 32'h100;
      m1_stb = 1'b1; m1_addr = 32'h200;
      #1;
      check_eq("cont1_m0_stall", {31'd0, m0_stall}, 32'd0);
      check_eq("cont1_m1_stall", {31'd0, m1_stall}, 32'd1);
      tick();
      m0_stb = 1'b0;
      #1;
      check_eq("cont1_s_addr", s_addr, 32'h100);
      check_eq("cont1_issue_stalls", {30'd0, m0_stall, m1_stall}, 32'd3);
      tick();
      s_ack = 1'b1; s_rdata = 32'hA0;
      tick();
      s_ack = 1'b0; s_rdata = 32'h0;
      m0_stb = 1'b1;
      #1;
      check_eq("cont1_m0_ack", {31'd0, m0_ack}, 32'd1);
      check_eq("cont1_m0_data", m0_rdata, 32'hA0);
      check_eq("cont2_m1_stall", {31'd0, m1_stall}, 32'd0);
      check_eq("cont2_m0_stall", {31'd0, m0_stall}, 32'd1);
      tick();
      m0_stb = 1'b0; m1_stb = 1'b0;
      #1;
      check_eq("cont2_s_addr", s_addr, 32'h200);
      check_eq("cont1_ack_one_cycle", {31'd0, m0_ack}, 32'd0);
      tick();
      s_ack = 1'b1; s_rdata = 32'hB1;
      tick();
      s_ack = 1'b0; s_rdata = 32'h0;
      #1;
      check_eq("cont2_m1_ack", {31'd0, m1_ack}, 32'd1);
      check_eq("cont2_m1_data", m1_rdata, 32'hB1);
      check_eq("cont2_m0_ack", {31'd0, m0_ack}, 32'd0);
      check_eq("cont2_m0_data", m0_rdata, 32'd0);
      tick();

      // Single read from m0 with a zero-wait slave: ack three cycles after accept.
      m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
      #1;
      check_eq("rd_m0_stall", {31'd0, m0_stall}, 32'd0);
      tick();
      m0_stb = 1'b0;
      #1;
      check_eq("rd_issue_stb", {31'd0, s_stb}, 32'd1);
      check_eq("rd_issue_addr", s_addr, 32'h10);
      check_eq("rd_issue_we", {31'd0, s_we}, 32'd0);
      tick();
      s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
      #1;
      check_eq("rd_wait_stb", {31'd0, s_stb}, 32'd0);
      check_eq("rd_wait_no_ack", {31'd0, m0_ack}, 32'd0);
      tick();
      s_ack = 1'b0; s_rdata = 32'h0;
      #1;
      check_eq("rd_m0_ack", {31'd0, m0_ack}, 32'd1);
      check_eq("rd_m0_data", m0_rdata, 32'hDEADBEEF);
      check_eq("rd_m0_err", {31'd0, m0_err}, 32'd0);
      check_eq("rd_m1_ack", {31'd0, m1_ack}, 32'd0);
      tick();
      check_eq("rd_ack_cleared", {31'd0, m0_ack}, 32'd0);
      check_eq("rd_data_cleared", m0_rdata, 32'd0);

      // Write from m1 through a slave that stalls four ISSUE cycles.
      m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 3'b010; m1_addr = 32'h24; m1_wdata = 32'h1234;
      s_stall = 1'b1;
      tick();
      m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 3'b000; m1_addr = 32'h0; m1_wdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) s_stall = 1'b0;
         #1;
         check_eq($sformatf("wr_stb_c%0d", c), {31'd0, s_stb}, 32'd1);
         check_eq($sformatf("wr_fields_c%0d", c), {s_we, s_sel, s_addr[11:0], s_wdata[15:0]},
                  {1'b1, 3'b010, 12'h024, 16'h1234});
         tick();
      end
      s_ack = 1'b1; s_rdata = 32'h55;
      #1;
      check_eq("wr_wait_stb", {31'd0, s_stb}, 32'd0);
      check_eq("wr_wait_addr", s_addr, 32'h24);
      tick();
      s_ack = 1'b0; s_rdata = 32'h0;
      #1;
      check_eq("wr_m1_ack", {31'd0, m1_ack}, 32'd1);
      check_eq("wr_m0_ack", {31'd0, m0_ack}, 32'd0);
      tick();

      // Timeout: m1 request never acked, err lands in cycle 16 after accept.
      m1_stb = 1'b1; m1_addr = 32'h40;
      tick();
      m1_stb = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         #1;
         check_eq($sformatf("tmo_quiet_c%0d", c), {30'd0, m1_err, m1_ack}, 32'd0);
         tick();
      end
      m0_stb = 1'b1; m0_addr = 32'h30;
      #1;
      check_eq("tmo_m1_err", {31'd0, m1_err}, 32'd1);
      check_eq("tmo_m1_ack", {31'd0, m1_ack}, 32'd0);
      check_eq("tmo_m0_err", {31'd0, m0_err}, 32'd0);
      check_eq("tmo_next_m0_stall", {31'd0, m0_stall}, 32'd0);
      tick();
      m0_stb = 1'b0;
      #1;
      check_eq("tmo_next_addr", s_addr, 32'h30);
      check_eq("tmo_err_one_cycle", {31'd0, m1_err}, 32'd0);

      // Reset while waiting in WAIT: the late ack must not surface.
      tick();
      check_eq("rw_in_wait", {31'd0, s_stb}, 32'd0);
      reset_n = 1'b0;
      #1;
      check_eq("rw_addr_cleared", s_addr, 32'd0);
      check_eq("rw_stalls_low", {30'd0, m0_stall, m1_stall}, 32'd0);
      tick();
      reset_n = 1'b1;
      s_ack = 1'b1; s_rdata = 32'h77;
      tick();
      s_ack = 1'b0; s_rdata = 32'h0;
      #1;
      check_eq("rw_no_pulse", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
      check_eq("rw_idle_no_stb", {31'd0, s_stb}, 32'd0);
      // Before the reset rr favoured m1; after it m0 must win a tie.
      m0_stb = 1'b1; m1_stb = 1'b1;
      #1;
      check_eq("rw_rr_m0_stall", {31'd0, m0_stall}, 32'd0);
      check_eq("rw_rr_m1_stall", {31'd0, m1_stall}, 32'd1);
      tick();
      m0_stb = 1'b0; m1_stb = 1'b0;
      #1;
      check_eq("rw_rr_addr", s_addr, 32'h30);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
